// File: rtl/rep_mul_pkg.sv
// Shared definitions for the repeated-addition multiplier: FSM state
// encoding, product-width helpers and a zero-extension function.
package rep_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10,
      ABRT = 2'b11
   } state_t;

   // Default operand width and the matching product width.
   localparam int WIDTH_DEF = 8;
   localparam int PW        = 2 * WIDTH_DEF;

   // Widest operand the zero-extension helper handles.
   localparam int MAX_W = 32;

   // Product width for an arbitrary operand width.
   function automatic int pw(input int width);
      return 2 * width;
   endfunction

   // Zero-extend an operand to double the helper width; callers truncate.
   function automatic logic [2*MAX_W-1:0] zext(input logic [MAX_W-1:0] v);
      return {{MAX_W{1'b0}}, v};
   endfunction

endpackage

// File: rtl/rep_add_mul_seq_if.sv
// Host-side bus of the repeated-addition multiplier.
// Handshake: a request is accepted on a rising clk edge where start=1 and
// ready=1; a and b are sampled on that edge only. Completion is a one-cycle
// done pulse (product valid and held) or a one-cycle aborted pulse.
interface rep_add_mul_seq_if #(
   parameter int WIDTH = 8
);
   logic               start;
   logic               abort;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               ready;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] product;
   logic               aborted;

   modport master (
      output start, abort, a, b,
      input  ready, busy, done, product, aborted
   );

   modport slave (
      input  start, abort, a, b,
      output ready, busy, done, product, aborted
   );
endinterface

// File: rtl/rep_mul_downcnt.sv
// WIDTH-bit loadable down-counter with a zero flag. Load has priority over
// decrement; decrementing at zero is not expected by the controller.
module rep_mul_downcnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;

   // Count register: load a new iteration count or step down by one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/rep_add_mul_seq.sv
// Sequential unsigned multiplier: product = a * b formed by adding the
// addend into an accumulator once per cycle for counter iterations.
// Optional build macro OPERAND_SWAP_EN: iterate over the smaller operand
// (counter = min(a,b), addend = max(a,b)) to shorten the latency.
// WIDTH must lie between 2 and rep_mul_pkg::MAX_W.
module rep_add_mul_seq
   import rep_mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   rep_add_mul_seq_if.slave   bus,
   output state_t             dbg_state
);

   localparam int PWL = pw(WIDTH);

   state_t           state_q, state_d;
   logic [PWL-1:0]   addend_q;
   logic [PWL-1:0]   acc_q;
   logic [PWL-1:0]   product_q;
   logic [WIDTH-1:0] op_add, op_cnt;
   logic             cnt_load, cnt_dec, cnt_zero;

   // Choose which operand is accumulated and which one sets the iteration count.
   always_comb begin
`ifdef OPERAND_SWAP_EN
      if (bus.a >= bus.b) begin
         op_add = bus.a;
         op_cnt = bus.b;
      end else begin
         op_add = bus.b;
         op_cnt = bus.a;
      end
`else
      op_add = bus.a;
      op_cnt = bus.b;
`endif
   end

   rep_mul_downcnt #(.WIDTH(WIDTH)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (op_cnt),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and counter control; abort only matters in RUN.
   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               cnt_load = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d = ABRT;
            end else if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         ABRT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: capture addend on accept, accumulate while counting, publish on completion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addend_q  <= '0;
         acc_q     <= '0;
         product_q <= '0;
      end else begin
         if (cnt_load) begin
            addend_q <= PWL'(zext(MAX_W'(op_add)));
            acc_q    <= '0;
         end
         if (cnt_dec) begin
            acc_q <= acc_q + addend_q;
         end
         if (state_q == RUN && state_d == DONE) begin
            product_q <= acc_q;
         end
      end
   end

   assign bus.ready   = (state_q == IDLE);
   assign bus.busy    = (state_q == RUN);
   assign bus.done    = (state_q == DONE);
   assign bus.aborted = (state_q == ABRT);
   assign bus.product = product_q;
   assign dbg_state   = state_q;

endmodule
